// File: rtl/box_mover.sv
// Keyboard-driven sprite stage: decodes PS/2 make/break sequences into held-key
// flags, moves a solid square once per frame and drives registered 1-bit RGB.
module box_mover #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 40,
    parameter int STEP     = 4,
    parameter int INIT_X   = 300,
    parameter int INIT_Y   = 220
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_strobe,
    input  logic [9:0] in_x,
    input  logic [8:0] in_y,
    input  logic [7:0] in_kbd_code,
    input  logic       in_kbd_valid,
    output logic       out_red,
    output logic       out_green,
    output logic       out_blue
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_EXT       = 2'd1;
    localparam logic [1:0] ST_BREAK     = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);
    localparam logic [10:0] H_W     = 11'(H_ACTIVE);
    localparam logic [10:0] V_W     = 11'(V_ACTIVE);
    localparam logic [10:0] X_MAX_W = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX_W = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  STEP_X  = 10'(STEP);
    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [8:0]  STEP_Y  = 9'(STEP);
    localparam logic [8:0]  Y_MAX   = 9'(V_ACTIVE - BOX_SIZE);

    logic [1:0]  state_q, state_d;
    logic [3:0]  held_q, held_d;     // {up, down, left, right}
    logic        space_q, space_d;
    logic [2:0]  colour_q, colour_d;
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic [2:0]  rgb_q, rgb_d;

    logic        is_make_s, is_brk_s, is_ext_s;
    logic [3:0]  key_vec_s;
    logic        key_space_s;
    logic        frame_tick_s;
    logic        inside_s;
    logic [9:0]  px_n_s;
    logic [8:0]  py_n_s;
    logic [10:0] px_w_s, py_w_s, x_w_s, y_w_s;

    // Scancode sequencer: classifies each received byte as make/release, plain/extended
    always_comb begin
        state_d   = state_q;
        is_make_s = 1'b0;
        is_brk_s  = 1'b0;
        is_ext_s  = 1'b0;
        if (in_kbd_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_kbd_code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (in_kbd_code == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else begin
                        is_make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (in_kbd_code == 8'hF0) begin
                        state_d = ST_EXT_BREAK;
                    end else begin
                        is_make_s = 1'b1;
                        is_ext_s  = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    is_brk_s = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT_BREAK: begin
                    is_brk_s = 1'b1;
                    is_ext_s = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Key map and held-flag / colour next state
    always_comb begin
        key_vec_s   = 4'b0000;
        key_space_s = 1'b0;
        if (is_ext_s) begin
            key_vec_s = {in_kbd_code == 8'h75, in_kbd_code == 8'h72,
                         in_kbd_code == 8'h6B, in_kbd_code == 8'h74};
        end else begin
            key_vec_s   = {in_kbd_code == 8'h1D, in_kbd_code == 8'h1B,
                           in_kbd_code == 8'h1C, in_kbd_code == 8'h23};
            key_space_s = (in_kbd_code == 8'h29);
        end

        held_d   = held_q;
        space_d  = space_q;
        colour_d = colour_q;
        if (is_make_s) begin
            held_d  = held_q | key_vec_s;
            space_d = space_q | key_space_s;
            // Only a fresh press of space (not a typematic repeat) steps the colour
            if (key_space_s && !space_q) begin
                colour_d = (colour_q == 3'b111) ? 3'b001 : colour_q + 3'b001;
            end else begin
                colour_d = colour_q;
            end
        end else if (is_brk_s) begin
            held_d  = held_q & ~key_vec_s;
            space_d = space_q & ~key_space_s;
        end else begin
            held_d = held_q;
        end
    end

    // Per-axis movement with clamping at the visible edges
    always_comb begin
        px_w_s = {1'b0, px_q};
        py_w_s = {2'b00, py_q};
        case (held_q[3:2])
            2'b10:   py_n_s = (py_w_s >= STEP_W) ? py_q - STEP_Y : 9'd0;
            2'b01:   py_n_s = ((py_w_s + STEP_W) > Y_MAX_W) ? Y_MAX : py_q + STEP_Y;
            default: py_n_s = py_q;
        endcase
        case (held_q[1:0])
            2'b10:   px_n_s = (px_w_s >= STEP_W) ? px_q - STEP_X : 10'd0;
            2'b01:   px_n_s = ((px_w_s + STEP_W) > X_MAX_W) ? X_MAX : px_q + STEP_X;
            default: px_n_s = px_q;
        endcase

        frame_tick_s = in_strobe && (in_x == 10'd0) && ({2'b00, in_y} == V_W);
        if (frame_tick_s) begin
            px_d = px_n_s;
            py_d = py_n_s;
        end else begin
            px_d = px_q;
            py_d = py_q;
        end
    end

    // Pixel hit test against the current square
    always_comb begin
        x_w_s    = {1'b0, in_x};
        y_w_s    = {2'b00, in_y};
        inside_s = (x_w_s >= px_w_s) && (x_w_s < px_w_s + BOX_W) &&
                   (y_w_s >= py_w_s) && (y_w_s < py_w_s + BOX_W) &&
                   (x_w_s < H_W) && (y_w_s < V_W);
        if (in_strobe) begin
            rgb_d = inside_s ? colour_q : 3'b000;
        end else begin
            rgb_d = rgb_q;
        end
    end

    // State registers
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q  <= ST_IDLE;
            held_q   <= 4'b0000;
            space_q  <= 1'b0;
            colour_q <= 3'b100;
            px_q     <= 10'(INIT_X);
            py_q     <= 9'(INIT_Y);
            rgb_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            space_q  <= space_d;
            colour_q <= colour_d;
            px_q     <= px_d;
            py_q     <= py_d;
            rgb_q    <= rgb_d;
        end
    end

    assign out_red   = rgb_q[2];
    assign out_green = rgb_q[1];
    assign out_blue  = rgb_q[0];

endmodule

// File: tb/tb_box_mover.sv
// Scoreboard bench for box_mover: a small position/colour model predicts each
// probed pixel; predictions are queued on drive and popped when the output registers.
module tb_box_mover;

    logic       clk = 1'b0;
    logic       rst;
    logic       strobe;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] code;
    logic       valid;
    logic       r, g, b;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int         mpx, mpy;
    logic [2:0] mcol;
    bit         mu, md, ml, mr;
    logic [2:0] exp_q[$];

    box_mover dut (
        .in_clock    (clk),
        .in_reset    (rst),
        .in_strobe   (strobe),
        .in_x        (x),
        .in_y        (y),
        .in_kbd_code (code),
        .in_kbd_valid(valid),
        .out_red     (r),
        .out_green   (g),
        .out_blue    (b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_rgb(input int px, input int py);
        if (px >= mpx && px < mpx + 40 && py >= mpy && py < mpy + 40 && px < 640 && py < 480)
            return mcol;
        return 3'b000;
    endfunction

    // drive one strobed pixel, push its expectation, then pop and compare
    task automatic pix_exp(input string tag, input int px, input int py, input logic [2:0] e);
        logic [2:0] want;
        @(negedge clk);
        x = px[9:0];
        y = py[8:0];
        strobe = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        strobe = 1'b0;
        want = exp_q.pop_front();
        check_val(tag, {r, g, b}, want);
    endtask

    task automatic pix(input string tag, input int px, input int py);
        logic [9:0] xm;
        logic [8:0] ym;
        xm = px[9:0];
        ym = py[8:0];
        pix_exp(tag, px, py, model_rgb(int'(xm), int'(ym)));
    endtask

    task automatic probe_box(input string tag);
        pix(tag, mpx, mpy);
        pix(tag, mpx - 1, mpy + 5);
        pix(tag, mpx + 39, mpy + 39);
        pix(tag, mpx + 40, mpy + 39);
        pix(tag, mpx + 5, mpy - 1);
        pix(tag, mpx + 5, mpy + 40);
    endtask

    task automatic key(input logic [7:0] k);
        @(negedge clk);
        code  = k;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask

    // frame tick; also checks the blanking pixel it lands on
    task automatic tick();
        pix_exp("tick_blank", 0, 480, 3'b000);
        if (mu && !md) mpy = (mpy >= 4) ? mpy - 4 : 0;
        else if (md && !mu) mpy = (mpy + 4 > 440) ? 440 : mpy + 4;
        if (ml && !mr) mpx = (mpx >= 4) ? mpx - 4 : 0;
        else if (mr && !ml) mpx = (mpx + 4 > 600) ? 600 : mpx + 4;
    endtask

    task automatic model_reset();
        mpx = 300; mpy = 220; mcol = 3'b100;
        mu = 0; md = 0; ml = 0; mr = 0;
    endtask

    initial begin
        int xs[8] = '{0, 299, 300, 339, 340, 639, 640, 700};
        int ys[8] = '{0, 219, 220, 259, 260, 479, 480, 500};
        rst = 1'b1; strobe = 1'b0; x = 10'd0; y = 9'd0; code = 8'h00; valid = 1'b0;
        model_reset();
        #23;
        check_val("reset_rgb", {r, g, b}, 3'b000);
        rst = 1'b0;

        // sparse frame scan across edges and blanking
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                pix("scan", xs[i], ys[j]);
        pix_exp("scan_in", 320, 240, 3'b100);

        // right held for three ticks
        key(8'hE0); key(8'h74); mr = 1;
        for (int i = 0; i < 3; i++) tick();
        key(8'hE0); key(8'hF0); key(8'h74); mr = 0;
        tick(); tick();
        pix_exp("right_edge_in", 312, 230, 3'b100);
        pix_exp("right_edge_out", 311, 230, 3'b000);
        probe_box("right");

        // up to the top clamp
        key(8'h1D); mu = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 53 || i == 54) probe_box("up_near0");
        end
        pix_exp("up_top", 313, 0, 3'b100);
        key(8'hF0); key(8'h1D); mu = 0;

        // down to the bottom clamp
        key(8'h1B); md = 1;
        for (int i = 0; i < 200; i++) tick();
        pix_exp("down_bot_in", 313, 479, 3'b100);
        pix_exp("down_bot_out", 313, 439, 3'b000);
        probe_box("down");
        key(8'hF0); key(8'h1B); md = 0;

        // opposing horizontal keys cancel
        key(8'hE0); key(8'h6B); ml = 1;
        key(8'hE0); key(8'h74); mr = 1;
        for (int i = 0; i < 5; i++) tick();
        probe_box("oppose");
        key(8'hE0); key(8'hF0); key(8'h6B); ml = 0;
        for (int i = 0; i < 3; i++) tick();
        probe_box("after_oppose");
        key(8'hE0); key(8'hF0); key(8'h74); mr = 0;

        // key event coinciding with a frame tick uses old flags
        @(negedge clk);
        code = 8'h23; valid = 1'b1; x = 10'd0; y = 9'd480; strobe = 1'b1;
        @(negedge clk);
        valid = 1'b0; strobe = 1'b0; mr = 1;
        probe_box("coincide");
        tick();
        probe_box("coincide_next");
        key(8'hF0); key(8'h23); mr = 0;

        // colour stepping and typematic repeats
        key(8'h29); mcol = 3'b101; probe_box("col_101");
        key(8'h29); key(8'h29); probe_box("col_repeat");
        key(8'hF0); key(8'h29);
        key(8'h29); mcol = 3'b110; probe_box("col_110");
        key(8'hF0); key(8'h29);
        key(8'h29); mcol = 3'b111; probe_box("col_111");
        key(8'hF0); key(8'h29);
        key(8'h29); mcol = 3'b001; probe_box("col_wrap");
        key(8'hF0); key(8'h29);

        // reset mid-sequence discards the E0 F0 prefix, asynchronously
        pix_exp("pre_rst", mpx + 2, mpy + 2, 3'b001);
        key(8'hE0);
        @(negedge clk); code = 8'hF0; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_val("async_rst", {r, g, b}, 3'b000);
        @(negedge clk); rst = 1'b0;
        model_reset();
        key(8'h74);
        tick();
        probe_box("post_rst");
        pix_exp("post_rst_col", 300, 220, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
